// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// serial_sub : bit-serial unsigned subtractor, D = A - B over N cycles, LSB first
// Revision   : 1.0
// ============================================================================
module serial_sub #(
    parameter int N = 8
) (
    input  logic         CLKIN,
    input  logic         RESETN,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] D,
    output logic         BOUT
);

    localparam int             CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [N-1:0]    sa_q;
    logic [N-1:0]    sb_q;
    logic [N-1:0]    sr_q;
    logic            carry_q;
    logic [CW-1:0]   count_q;
    logic            busy_q;
    logic            done_q;
    logic [N-1:0]    d_q;
    logic            bout_q;

    // One full-adder slice: A + ~B + carry, carry seeded with 1 for two's complement.
    logic            nb_w;
    logic            sum_d;
    logic            carry_d;
    logic [N-1:0]    sr_d;

    always_comb begin
        nb_w    = ~sb_q[0];
        sum_d   = sa_q[0] ^ nb_w ^ carry_q;
        carry_d = (sa_q[0] & nb_w) | (sa_q[0] & carry_q) | (nb_w & carry_q);
        sr_d    = {sum_d, sr_q[N-1:1]};
    end

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        sa_q    <= A;
                        sb_q    <= B;
                        carry_q <= 1'b1;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sa_q    <= {1'b0, sa_q[N-1:1]};
                    sb_q    <= {1'b0, sb_q[N-1:1]};
                    sr_q    <= sr_d;
                    carry_q <= carry_d;
                    count_q <= count_q + 1'b1;
                    // Results are published only once the last bit is through the slice.
                    if (count_q == LAST) begin
                        d_q     <= sr_d;
                        bout_q  <= ~carry_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign D    = d_q;
    assign BOUT = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// tb_serial_sub : randomized self-checking bench for serial_sub (N = 8)
// Revision      : 1.0
// ============================================================================
module tb_serial_sub;

    localparam int N = 8;

    logic         clk   = 1'b0;
    logic         rstn  = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] a     = '0;
    logic [N-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] d;
    logic         bout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_sub #(.N(N)) dut (
        .CLKIN  (clk),
        .RESETN (rstn),
        .START  (start),
        .A      (a),
        .B      (b),
        .BUSY   (busy),
        .DONE   (done),
        .D      (d),
        .BOUT   (bout)
    );

    // Reference: plain unsigned arithmetic, {borrow, difference mod 2^N}.
    function automatic logic [N:0] ref_sub(input logic [N-1:0] va, input logic [N-1:0] vb);
        logic [N:0] wide;
        wide = {1'b0, va} - {1'b0, vb};
        return {(va < vb), wide[N-1:0]};
    endfunction

    task automatic start_op(input logic [N-1:0] va, input logic [N-1:0] vb);
        @(negedge clk);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for DONE; optionally jams START/A/B with junk while running and
    // flags any change of D before DONE.
    task automatic wait_done(input int limit, input bit jam, input logic [N-1:0] prev_d,
                             output int edges, output bit seen, output bit held);
        seen  = 1'b0;
        held  = 1'b1;
        edges = 0;
        while (!seen && edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
            if (done === 1'b1) begin
                seen  = 1'b1;
                start = 1'b0;
            end else begin
                if (d !== prev_d) held = 1'b0;
                if (jam) begin
                    start = 1'($urandom_range(0, 1));
                    a     = N'($urandom);
                    b     = N'($urandom);
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
        checks++; if (d !== '0)      begin errors++; $display("FAIL reset_d got %0h exp 0", d); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %0b exp 0", bout); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic;
        int         nbusy;
        int         dedge;
        logic [N-1:0] dv;
        logic       bv;
        bit         after_done_low;
        logic [N:0] exp;
        exp = ref_sub(8'h50, 8'h20);
        start_op(8'h50, 8'h20);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise got %0b exp 1", busy); end
        nbusy = (busy === 1'b1) ? 1 : 0;
        dedge = -1;
        dv    = '0;
        bv    = 1'b0;
        after_done_low = 1'b1;
        for (int i = 1; i <= N + 2; i++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) nbusy++;
            if (dedge >= 0 && done !== 1'b0) after_done_low = 1'b0;
            if (done === 1'b1 && dedge < 0) begin
                dedge = i;
                dv    = d;
                bv    = bout;
            end
        end
        checks++; if (dedge != N)    begin errors++; $display("FAIL done_latency got %0d exp %0d", dedge, N); end
        checks++; if (nbusy != N + 1) begin errors++; $display("FAIL busy_len got %0d exp %0d", nbusy, N + 1); end
        checks++; if (!after_done_low) begin errors++; $display("FAIL done_pulse got long exp single"); end
        checks++; if (dv !== exp[N-1:0]) begin errors++; $display("FAIL basic_d got %0h exp %0h", dv, exp[N-1:0]); end
        checks++; if (bv !== exp[N])     begin errors++; $display("FAIL basic_bout got %0b exp %0b", bv, exp[N]); end
    endtask

    task automatic test_pair(input logic [N-1:0] va, input logic [N-1:0] vb);
        int edges;
        bit seen, held;
        logic [N:0] exp;
        logic [N-1:0] prev;
        exp  = ref_sub(va, vb);
        prev = d;
        start_op(va, vb);
        wait_done(4 * N, 1'b0, prev, edges, seen, held);
        checks++; if (!seen || edges != N) begin errors++; $display("FAIL pair_latency a=%0h b=%0h got %0d exp %0d", va, vb, edges, N); end
        checks++; if (d !== exp[N-1:0])   begin errors++; $display("FAIL pair_d a=%0h b=%0h got %0h exp %0h", va, vb, d, exp[N-1:0]); end
        checks++; if (bout !== exp[N])    begin errors++; $display("FAIL pair_bout a=%0h b=%0h got %0b exp %0b", va, vb, bout, exp[N]); end
        checks++; if (!held)              begin errors++; $display("FAIL pair_hold got changed exp %0h", prev); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_ignore_start;
        int ndone;
        bit held;
        logic [N-1:0] prev;
        logic [N:0] exp;
        exp   = ref_sub(8'h10, 8'h01);
        prev  = d;
        held  = 1'b1;
        ndone = 0;
        start_op(8'h10, 8'h01);
        for (int i = 1; i <= 3 * N; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                checks++; if (d !== exp[N-1:0]) begin errors++; $display("FAIL ignore_d got %0h exp %0h", d, exp[N-1:0]); end
                checks++; if (bout !== exp[N])  begin errors++; $display("FAIL ignore_bout got %0b exp %0b", bout, exp[N]); end
                prev  = d;
                a     = 8'h99;
                b     = 8'h11;
                start = 1'b1;
            end else if (d !== prev) begin
                held = 1'b0;
            end
            if (i == 3) begin
                a     = 8'h99;
                b     = 8'h11;
                start = 1'b1;
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_pulses got %0d exp 1", ndone); end
        checks++; if (!held)      begin errors++; $display("FAIL ignore_hold got changed exp stable"); end
    endtask

    task automatic test_reset_midrun;
        int  edges;
        bit  seen, held;
        bit  saw_done;
        logic [N:0] exp;
        start_op(8'h80, 8'h01);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %0b exp 0", done); end
        checks++; if (d !== '0)      begin errors++; $display("FAIL midrst_d got %0h exp 0", d); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL midrst_bout got %0b exp 0", bout); end
        saw_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL midrst_activity got active exp idle"); end
        exp = ref_sub(8'h03, 8'h05);
        start_op(8'h03, 8'h05);
        wait_done(4 * N, 1'b0, d, edges, seen, held);
        checks++; if (!seen || d !== exp[N-1:0]) begin errors++; $display("FAIL postrst_d got %0h exp %0h", d, exp[N-1:0]); end
        checks++; if (bout !== exp[N])          begin errors++; $display("FAIL postrst_bout got %0b exp %0b", bout, exp[N]); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        int pulses[$];
        logic [N:0] exp;
        exp = ref_sub(8'h07, 8'h02);
        @(negedge clk);
        a     = 8'h07;
        b     = 8'h02;
        start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                pulses.push_back(i);
                checks++; if (d !== exp[N-1:0]) begin errors++; $display("FAIL b2b_d edge=%0d got %0h exp %0h", i, d, exp[N-1:0]); end
            end
        end
        start = 1'b0;
        checks++; if (pulses.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", pulses.size()); end
        if (pulses.size() == 3) begin
            checks++; if (pulses[0] != N + 1)     begin errors++; $display("FAIL b2b_first got %0d exp %0d", pulses[0], N + 1); end
            checks++; if (pulses[1] - pulses[0] != N + 2 || pulses[2] - pulses[1] != N + 2) begin
                errors++; $display("FAIL b2b_period got %0d,%0d exp %0d", pulses[1] - pulses[0], pulses[2] - pulses[1], N + 2);
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        int edges;
        bit seen, held;
        int bad;
        logic [N-1:0] va, vb, prev;
        logic [N:0] exp;
        bad = 0;
        for (int n = 0; n < 1000; n++) begin
            va   = N'($urandom);
            vb   = ($urandom_range(0, 15) == 0) ? va : N'($urandom);
            exp  = ref_sub(va, vb);
            prev = d;
            start_op(va, vb);
            wait_done(4 * N, 1'b1, prev, edges, seen, held);
            checks++;
            if (!seen || edges != N || d !== exp[N-1:0] || bout !== exp[N] || !held) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand a=%0h b=%0h got d=%0h bout=%0b lat=%0d held=%0b exp d=%0h bout=%0b lat=%0d",
                             va, vb, d, bout, edges, held, exp[N-1:0], exp[N], N);
                bad++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pair(8'h20, 8'h50);
        test_pair(8'h00, 8'h01);
        test_pair(8'hA5, 8'hA5);
        test_pair(8'hFF, 8'h00);
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
